// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: turns the raw PS/2 scancode byte stream into decoded key events
// and buffers them in a first-word fall-through FIFO.
//
// Each event is {code, ext, brk}:
//   ext - the code was preceded by an E0 prefix
//   brk - the code was preceded by an F0 prefix (key release)
// Keyboard status bytes (AA, FA, FC, 00, FF) are never stored, and they cancel
// any prefix that is pending. A prefix that is not followed by another byte
// within TIMEOUT clk cycles is dropped.
//
// Parameters
//   FIFO_DEPTH   number of buffered events (power of two, >= 2)
//   TIMEOUT      clk cycles allowed between a prefix byte and the next byte
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous active-low reset
//   rx_done_tick one-cycle strobe from the PS/2 receiver: rx_data is valid
//   rx_data      received byte
//   rd_en        pop the head event (ignored while empty)
//   key_code     head event scancode (0 while empty)
//   key_ext      head event was E0-prefixed (0 while empty)
//   key_brk      head event is a release (0 while empty)
//   empty        no events stored
//   full         FIFO_DEPTH events stored
//   count        number of stored events
//   overflow     sticky: an event was dropped because the FIFO was full
module ps2_key_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_done_tick,
    input  logic [7:0]                    rx_data,
    input  logic                          rd_en,
    output logic [7:0]                    key_code,
    output logic                          key_ext,
    output logic                          key_brk,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    // Encoding is {ext_pending, brk_pending} so a prefix byte just sets its bit.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_BRK    = 2'b01,
        S_EXT    = 2'b10,
        S_EXTBRK = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            is_e0, is_f0, is_status;
    logic            push, push_ext, push_brk;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            fifo_empty, fifo_full;
    logic            pop, wr_ok;
    logic [9:0]      head;

    // ------------------------------------------------------------------
    // Byte classification
    // ------------------------------------------------------------------
    always_comb begin
        is_e0     = (rx_data == 8'hE0);
        is_f0     = (rx_data == 8'hF0);
        is_status = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFC) ||
                    (rx_data == 8'h00) || (rx_data == 8'hFF);
    end

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        push_ext = 1'b0;
        push_brk = 1'b0;

        if (rx_done_tick) begin
            if (is_status) begin
                state_d = S_IDLE;
            end else if (is_e0) begin
                state_d = state_t'({1'b1, state_q[0]});
            end else if (is_f0) begin
                state_d = state_t'({state_q[1], 1'b1});
            end else begin
                push     = 1'b1;
                push_ext = state_q[1];
                push_brk = state_q[0];
                state_d  = S_IDLE;
            end
        end else if (state_q != S_IDLE && timer_q == TIMER_MAX) begin
            // Prefix went stale; abandon it without producing an event.
            state_d = S_IDLE;
        end
    end

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (rx_done_tick || state_q == S_IDLE) begin
            timer_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_CNT);
        pop        = rd_en && !fifo_empty;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        wr_ok      = push && (!fifo_full || pop);

        wr_ptr_d   = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q || (push && !wr_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: nothing is visible unless count says so.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) begin
            mem[wr_ptr_q] <= {rx_data, push_ext, push_brk};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Status is forced while reset is held so it is correct even before the
    // first reset edge has cleared the counters.
    always_comb begin
        head     = mem[rd_ptr_q];
        empty    = !reset || fifo_empty;
        full     = reset && fifo_full;
        key_code = empty ? 8'h00 : head[9:2];
        key_ext  = empty ? 1'b0 : head[1];
        key_brk  = empty ? 1'b0 : head[0];
        count    = count_q;
        overflow = overflow_q;
    end

endmodule
